// File: rtl/taillight_pkg.sv
// rtl/taillight_pkg.sv - shared types and lamp patterns for the tail-light bus
package taillight_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_HAZ   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_DARK_IDLE = 2'b00,
        ST_ACTIVE    = 2'b01,
        ST_DARK_END  = 2'b10,
        ST_LOST      = 2'b11
    } trk_state_t;

    // Lamp bus: [5:3] left lamps (bit3 innermost), [2:0] right lamps (bit2 innermost)
    localparam logic [5:0] LAMP_DARK    = 6'b000000;
    localparam logic [5:0] LAMP_LEFT_1  = 6'b001000;
    localparam logic [5:0] LAMP_LEFT_2  = 6'b011000;
    localparam logic [5:0] LAMP_LEFT_3  = 6'b111000;
    localparam logic [5:0] LAMP_RIGHT_1 = 6'b000100;
    localparam logic [5:0] LAMP_RIGHT_2 = 6'b000110;
    localparam logic [5:0] LAMP_RIGHT_3 = 6'b000111;
    localparam logic [5:0] LAMP_HAZ_1   = 6'b001100;
    localparam logic [5:0] LAMP_HAZ_2   = 6'b011110;
    localparam logic [5:0] LAMP_HAZ_3   = 6'b111111;

endpackage

// File: rtl/lamp_pattern_decode.sv
// rtl/lamp_pattern_decode.sv - combinational lamp bus decoder to {valid, mode, phase}
module lamp_pattern_decode
    import taillight_pkg::*;
(
    input  logic [5:0] i_lamp,
    output logic       o_valid,
    output mode_t      o_mode,
    output logic [1:0] o_phase
);

    // Map each legal pattern to its mode and step; DARK is valid with phase 0
    always_comb begin
        o_valid = 1'b1;
        o_mode  = MODE_IDLE;
        o_phase = 2'd0;
        case (i_lamp)
            LAMP_DARK:    begin o_mode = MODE_IDLE;  o_phase = 2'd0; end
            LAMP_LEFT_1:  begin o_mode = MODE_LEFT;  o_phase = 2'd1; end
            LAMP_LEFT_2:  begin o_mode = MODE_LEFT;  o_phase = 2'd2; end
            LAMP_LEFT_3:  begin o_mode = MODE_LEFT;  o_phase = 2'd3; end
            LAMP_RIGHT_1: begin o_mode = MODE_RIGHT; o_phase = 2'd1; end
            LAMP_RIGHT_2: begin o_mode = MODE_RIGHT; o_phase = 2'd2; end
            LAMP_RIGHT_3: begin o_mode = MODE_RIGHT; o_phase = 2'd3; end
            LAMP_HAZ_1:   begin o_mode = MODE_HAZ;   o_phase = 2'd1; end
            LAMP_HAZ_2:   begin o_mode = MODE_HAZ;   o_phase = 2'd2; end
            LAMP_HAZ_3:   begin o_mode = MODE_HAZ;   o_phase = 2'd3; end
            default:      o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/taillight_monitor.sv
// rtl/taillight_monitor.sv - lamp sequence checker with error flags and sequence counter
module taillight_monitor
    import taillight_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [5:0]       lamp,
    input  logic             err_clr,
    output logic [1:0]       mode,
    output logic [1:0]       phase,
    output logic             in_sync,
    output logic             seq_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] cycle_cnt
);

    logic       w_dec_valid;
    mode_t      w_dec_mode;
    logic [1:0] w_dec_phase;
    logic       w_is_dark;
    logic       w_is_p1;
    logic       w_step_ok;

    trk_state_t r_state;
    mode_t      r_mode;
    logic [1:0] r_phase;

    lamp_pattern_decode u_decode (
        .i_lamp  (lamp),
        .o_valid (w_dec_valid),
        .o_mode  (w_dec_mode),
        .o_phase (w_dec_phase)
    );

    // Classify the current sample against what the tracker allows next
    always_comb begin
        w_is_dark = w_dec_valid && (w_dec_phase == 2'd0);
        w_is_p1   = w_dec_valid && (w_dec_phase == 2'd1);
        w_step_ok = 1'b1;
        case (r_state)
            ST_DARK_IDLE, ST_DARK_END: w_step_ok = w_is_dark || w_is_p1;
            ST_ACTIVE: begin
                if (r_phase == 2'd3)
                    w_step_ok = w_is_dark;
                else
                    w_step_ok = w_dec_valid && (w_dec_mode == r_mode)
                                && (w_dec_phase == r_phase + 2'd1);
            end
            default:                   w_step_ok = 1'b1;
        endcase
    end

    // Tracker FSM with registered outputs, error flags and saturating counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_DARK_IDLE;
            r_mode     <= MODE_IDLE;
            r_phase    <= 2'd0;
            in_sync    <= 1'b1;
            seq_err    <= 1'b0;
            err_sticky <= 1'b0;
            cycle_cnt  <= '0;
        end else begin
            seq_err <= 1'b0;
            // Clear first so a same-cycle error set below takes priority
            if (err_clr)
                err_sticky <= 1'b0;
            if (sample_en) begin
                if (r_state == ST_LOST) begin
                    if (w_is_dark) begin
                        r_state <= ST_DARK_IDLE;
                        in_sync <= 1'b1;
                    end
                end else if (!w_step_ok) begin
                    seq_err    <= 1'b1;
                    err_sticky <= 1'b1;
                    if (w_is_p1) begin
                        r_state <= ST_ACTIVE;
                        r_mode  <= w_dec_mode;
                        r_phase <= 2'd1;
                    end else begin
                        r_state <= ST_LOST;
                        r_mode  <= MODE_IDLE;
                        r_phase <= 2'd0;
                        in_sync <= 1'b0;
                    end
                end else if (w_is_dark) begin
                    r_phase <= 2'd0;
                    if (r_state == ST_ACTIVE) begin
                        // Only the phase-3 -> dark step passes w_step_ok here
                        r_state <= ST_DARK_END;
                        if (cycle_cnt != {CNT_W{1'b1}})
                            cycle_cnt <= cycle_cnt + 1'b1;
                    end else begin
                        r_state <= ST_DARK_IDLE;
                        r_mode  <= MODE_IDLE;
                    end
                end else begin
                    r_state <= ST_ACTIVE;
                    r_mode  <= w_dec_mode;
                    r_phase <= w_dec_phase;
                end
            end
        end
    end

    assign mode  = r_mode;
    assign phase = r_phase;

endmodule

// File: tb/tb_taillight_monitor.sv
// tb/tb_taillight_monitor.sv - randomized self-checking bench for taillight_monitor
module tb_taillight_monitor;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sample_en = 1'b0;
    logic [5:0]       lamp = 6'd0;
    logic             err_clr = 1'b0;
    logic [1:0]       mode;
    logic [1:0]       phase;
    logic             in_sync;
    logic             seq_err;
    logic             err_sticky;
    logic [CNT_W-1:0] cycle_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // pat_tbl[mode][step] : mode 1=LEFT 2=RIGHT 3=HAZ, step 1..3
    logic [5:0] pat_tbl [1:3][1:3];

    // Reference model: position within the legal lamp sequences
    int m_mode, m_phase, m_cnt;
    bit m_lost, m_err, m_sticky;

    taillight_monitor #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_en  (sample_en),
        .lamp       (lamp),
        .err_clr    (err_clr),
        .mode       (mode),
        .phase      (phase),
        .in_sync    (in_sync),
        .seq_err    (seq_err),
        .err_sticky (err_sticky),
        .cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string ctx);
        check_eq({ctx, ".mode"},       int'(mode),       m_mode);
        check_eq({ctx, ".phase"},      int'(phase),      m_phase);
        check_eq({ctx, ".in_sync"},    int'(in_sync),    int'(!m_lost));
        check_eq({ctx, ".seq_err"},    int'(seq_err),    int'(m_err));
        check_eq({ctx, ".err_sticky"}, int'(err_sticky), int'(m_sticky));
        check_eq({ctx, ".cycle_cnt"},  int'(cycle_cnt),  m_cnt);
    endtask

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_cnt = 0;
        m_lost = 0; m_err = 0; m_sticky = 0;
    endtask

    // Returns step 0 for dark, 1..3 for a legal pattern, -1 for invalid
    task automatic lookup(input logic [5:0] lv, output int lm, output int lp);
        lm = 0;
        lp = (lv == 6'd0) ? 0 : -1;
        for (int mm = 1; mm <= 3; mm++)
            for (int pp = 1; pp <= 3; pp++)
                if (pat_tbl[mm][pp] == lv) begin
                    lm = mm;
                    lp = pp;
                end
    endtask

    task automatic model_step(input logic en, input logic [5:0] lv, input logic clr);
        int  lm, lp;
        bit  legal;
        m_err = 0;
        if (clr) m_sticky = 0;
        if (!en) return;
        lookup(lv, lm, lp);
        if (m_lost) begin
            if (lp == 0) m_lost = 0;
            return;
        end
        if (m_phase == 0)      legal = (lp == 0) || (lp == 1);
        else if (m_phase == 3) legal = (lp == 0);
        else                   legal = (lm == m_mode) && (lp == m_phase + 1);
        if (!legal) begin
            m_err = 1;
            m_sticky = 1;
            if (lp == 1) begin
                m_mode = lm; m_phase = 1;
            end else begin
                m_lost = 1; m_mode = 0; m_phase = 0;
            end
        end else if (lp == 0) begin
            if (m_phase == 3) begin
                m_phase = 0;
                if (m_cnt < CNT_MAX) m_cnt++;
            end else begin
                m_mode = 0;
            end
        end else begin
            m_mode = lm; m_phase = lp;
        end
    endtask

    task automatic run_cycle(input logic en, input logic [5:0] lv, input logic clr);
        sample_en = en;
        lamp      = lv;
        err_clr   = clr;
        @(posedge clk);
        model_step(en, lv, clr);
        @(negedge clk);
        check_all("step");
    endtask

    // Mostly-legal stimulus so sequences complete, with regular corruption
    function automatic logic [5:0] pick_lamp();
        int r;
        int rm;
        r = $urandom_range(0, 99);
        if (r < 75) begin
            if (m_lost)            return ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
            if (m_phase == 0) begin
                rm = $urandom_range(0, 3);
                return (rm == 0) ? 6'd0 : pat_tbl[rm][1];
            end
            if (m_phase == 3)      return 6'd0;
            return pat_tbl[m_mode][m_phase + 1];
        end else if (r < 90) begin
            rm = $urandom_range(1, 3);
            return pat_tbl[rm][$urandom_range(1, 3)];
        end
        return 6'($urandom);
    endfunction

    initial begin
        pat_tbl[1][1] = 6'b001000; pat_tbl[1][2] = 6'b011000; pat_tbl[1][3] = 6'b111000;
        pat_tbl[2][1] = 6'b000100; pat_tbl[2][2] = 6'b000110; pat_tbl[2][3] = 6'b000111;
        pat_tbl[3][1] = 6'b001100; pat_tbl[3][2] = 6'b011110; pat_tbl[3][3] = 6'b111111;

        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        reset = 1'b0;

        // Directed: LEFT twice, then an illegal jump to RIGHT phase 3
        for (int k = 0; k < 2; k++)
            for (int s = 0; s <= 3; s++)
                run_cycle(1'b1, (s == 3) ? 6'd0 : pat_tbl[1][s + 1], 1'b0);
        run_cycle(1'b1, 6'b001000, 1'b0);
        run_cycle(1'b1, 6'b011000, 1'b0);
        run_cycle(1'b1, 6'b000111, 1'b0);
        run_cycle(1'b1, 6'b101010, 1'b1);
        run_cycle(1'b1, 6'b000000, 1'b0);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                check_all("async_reset");
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
            end
            run_cycle($urandom_range(0, 99) < 85,
                      pick_lamp(),
                      $urandom_range(0, 99) < 5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
